// File: rtl/jpeg_pkg.sv
// jpeg_pkg: shared coefficient width, encoder states and output symbol layout
package jpeg_pkg;
  localparam int COEF_W = 11;
  typedef enum logic [1:0] {IDLE, DC, AC, EOB} state_t;
  typedef struct packed {
    logic [3:0]        run;
    logic [3:0]        size;
    logic [COEF_W-1:0] amp;
    logic              dc;
    logic              last;
  } sym_t;
endpackage

// File: rtl/coef_category.sv
// coef_category: JPEG magnitude category and right-aligned amplitude bits of a signed value
module coef_category #(
  parameter int W  = 12,
  parameter int AW = 11
) (
  input  logic [W-1:0]  value,
  output logic [3:0]    size,
  output logic [AW-1:0] amp
);
  logic [W-1:0] mag, raw, mask;
  // size is the bit length of |value|; negatives send value-1 truncated to size bits
  always_comb begin
    mag = value[W-1] ? (~value + W'(1)) : value;
    size = '0;
    for (int i = 0; i < W; i++) if (mag[i]) size = 4'(i + 1);
    raw = value[W-1] ? value - W'(1) : value;
    mask = ~({W{1'b1}} << size);
    amp = AW'(raw & mask);
  end
endmodule

// File: rtl/rle_encoder.sv
// rle_encoder: turns one zig-zag block into a DC difference plus AC run/size/amplitude symbols
module rle_encoder
  import jpeg_pkg::*;
#(
  parameter int COEF_W = jpeg_pkg::COEF_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [63:0][COEF_W-1:0] in_block,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   dc_clear,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0]             out_run,
  output logic [3:0]             out_size,
  output logic [COEF_W-1:0]      out_amp,
  output logic                   out_dc,
  output logic                   out_last
);
  state_t                    state, state_nx;
  logic [63:0][COEF_W-1:0]   blk;
  logic [5:0]                idx;
  logic [3:0]                run;
  logic [COEF_W-1:0]         prev_dc;
  logic [COEF_W:0]           dc_diff;
  logic [63:0]               nz;
  logic                      rest_nz, cur_zero;
  logic [COEF_W-1:0]         cur;
  logic [COEF_W:0]           cat_in;
  logic [3:0]                cat_size;
  logic [COEF_W-1:0]         cat_amp;
  sym_t                      sym;

  assign cur      = blk[idx];
  assign cur_zero = ~nz[idx];
  assign rest_nz  = |(nz & ({64{1'b1}} << idx));
  assign cat_in   = (state == DC) ? dc_diff : {cur[COEF_W-1], cur};
  assign in_ready = (state == IDLE);
  assign out_run  = sym.run;
  assign out_size = sym.size;
  assign out_amp  = sym.amp;
  assign out_dc   = sym.dc;
  assign out_last = sym.last;

  coef_category #(.W(COEF_W + 1), .AW(COEF_W)) u_cat (
    .value(cat_in),
    .size (cat_size),
    .amp  (cat_amp)
  );

  // per-coefficient nonzero flags drive the end-of-block lookahead
  always_comb begin
    nz = '0;
    for (int i = 0; i < 64; i++) nz[i] = |blk[i];
  end

  // next state and the symbol presented in the current state
  always_comb begin
    sym = '0;
    out_valid = 1'b0;
    state_nx = state;
    case (state)
      IDLE: state_nx = in_valid ? DC : IDLE;
      DC: begin
        out_valid = 1'b1;
        sym.dc = 1'b1;
        sym.size = cat_size;
        sym.amp = cat_amp;
        state_nx = out_ready ? AC : DC;
      end
      AC: begin
        if (!rest_nz) state_nx = EOB;
        else if (!cur_zero || run == 4'd15) begin
          out_valid = 1'b1;
          sym.run = run;
          sym.size = cat_size;
          sym.amp = cat_amp;
          sym.last = !cur_zero && idx == 6'd63;
          state_nx = (out_ready && sym.last) ? IDLE : AC;
        end
      end
      default: begin
        out_valid = 1'b1;
        sym.last = 1'b1;
        state_nx = out_ready ? IDLE : EOB;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;

  // block capture, DC predictor and AC scan position; the DC difference is frozen at acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk <= '0;
      idx <= '0;
      run <= '0;
      prev_dc <= '0;
      dc_diff <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        blk <= in_block;
        dc_diff <= {in_block[0][COEF_W-1], in_block[0]} -
                   (dc_clear ? {(COEF_W+1){1'b0}} : {prev_dc[COEF_W-1], prev_dc});
      end
      if (state == DC && out_ready) begin
        prev_dc <= blk[0];
        idx <= 6'd1;
        run <= '0;
      end else if (dc_clear) prev_dc <= '0;
      if (state == AC && rest_nz && cur_zero && run != 4'd15) begin
        run <= run + 4'd1;
        idx <= idx + 6'd1;
      end else if (state == AC && rest_nz && out_ready) begin
        run <= '0;
        idx <= idx + 6'd1;
      end
    end
  end
endmodule

// File: tb/tb_rle_encoder.sv
// tb_rle_encoder: directed blocks checked against a symbol-list model and hand literals
module tb_rle_encoder;
  import jpeg_pkg::*;
  localparam int W = COEF_W;
  logic clk = 0, rst = 1;
  logic [63:0][W-1:0] in_block = '0;
  logic in_valid = 0, in_ready, dc_clear = 0, out_valid, out_ready = 1;
  logic [3:0] out_run, out_size;
  logic [W-1:0] out_amp;
  logic out_dc, out_last;
  int checks = 0, errors = 0, m_prev = 0;
  bit rand_en = 0, prev_stall = 0;
  sym_t exp_q[$], cap_q[$], lit_q[$];
  sym_t got, prev_sym;
  logic [63:0][W-1:0] b;

  assign got = {out_run, out_size, out_amp, out_dc, out_last};

  rle_encoder #(.COEF_W(W)) dut (
    .clk(clk), .rst(rst), .in_block(in_block), .in_valid(in_valid), .in_ready(in_ready),
    .dc_clear(dc_clear), .out_valid(out_valid), .out_ready(out_ready), .out_run(out_run),
    .out_size(out_size), .out_amp(out_amp), .out_dc(out_dc), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic sym_t mk(input int r, input int s, input int a, input bit d, input bit l);
    sym_t x;
    x.run = 4'(r);
    x.size = 4'(s);
    x.amp = W'(a);
    x.dc = d;
    x.last = l;
    return x;
  endfunction

  function automatic int sz(input int v);
    int a = (v < 0) ? -v : v;
    int s = 0;
    while (a > 0) begin
      s++;
      a = a >> 1;
    end
    return s;
  endfunction

  function automatic int am(input int v);
    return (v >= 0) ? v : v + (1 << sz(v)) - 1;
  endfunction

  // expected symbol list: JPEG baseline run-length rules over the coefficient array
  function automatic void model(input logic [63:0][W-1:0] blk, input int prev);
    int lastnz = 0, zeros = 0, v;
    for (int i = 1; i < 64; i++) if (blk[i] != 0) lastnz = i;
    v = int'($signed(blk[0])) - prev;
    exp_q.push_back(mk(0, sz(v), am(v), 1, 0));
    for (int i = 1; i <= lastnz; i++) begin
      v = int'($signed(blk[i]));
      if (v == 0) begin
        zeros++;
        if (zeros == 16) begin
          exp_q.push_back(mk(15, 0, 0, 0, 0));
          zeros = 0;
        end
      end else begin
        exp_q.push_back(mk(zeros, sz(v), am(v), 0, i == 63));
        zeros = 0;
      end
    end
    if (lastnz < 63) exp_q.push_back(mk(0, 0, 0, 0, 1));
  endfunction

  // compare every presented symbol with the model and check stall stability
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_valid", int'(out_valid), 0);
      prev_stall = 0;
    end else begin
      if (prev_stall) chk("stall_hold", int'(got), int'(prev_sym));
      if (out_valid) begin
        if (exp_q.size() == 0) chk("extra_sym", int'(out_valid), 0);
        else begin
          chk("sym", int'(got), int'(exp_q[0]));
          if (out_ready) begin
            cap_q.push_back(got);
            void'(exp_q.pop_front());
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_sym = got;
    end
  end

  // consumer backpressure
  always @(posedge clk) begin
    #1;
    out_ready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic send(input logic [63:0][W-1:0] blk, input bit clr_dc);
    int n = 0;
    cap_q.delete();
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", int'(in_ready), 1);
    model(blk, m_prev);
    m_prev = int'($signed(blk[0]));
    in_block = blk;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    for (int i = 0; i < 64; i++) in_block[i] = W'($urandom);
    chk("dc_latency", int'(out_valid && out_dc), 1);
    if (clr_dc) begin
      dc_clear = 1;
      @(posedge clk); #1;
      dc_clear = 0;
    end
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic clear_dc();
    dc_clear = 1;
    @(posedge clk); #1;
    dc_clear = 0;
    m_prev = 0;
  endtask

  task automatic cmp_lits(input string name);
    chk({name, "_count"}, cap_q.size(), lit_q.size());
    for (int i = 0; i < lit_q.size() && i < cap_q.size(); i++) chk(name, int'(cap_q[i]), int'(lit_q[i]));
    lit_q.delete();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", int'(got), 0);
    rst = 0;
    #1;
    chk("ready_after_rst", int'(in_ready), 1);
    chk("idle_valid", int'(out_valid), 0);
    b = '0;
    send(b, 0);
    lit_q.push_back(mk(0, 0, 0, 1, 0));
    lit_q.push_back(mk(0, 0, 0, 0, 1));
    cmp_lits("all_zero");
    b = '0; b[0] = -11'sd3; b[1] = 11'd5;
    send(b, 0);
    lit_q.push_back(mk(0, 2, 0, 1, 0));
    lit_q.push_back(mk(0, 3, 5, 0, 0));
    lit_q.push_back(mk(0, 0, 0, 0, 1));
    cmp_lits("neg_dc");
    clear_dc();
    b = '0; b[20] = 11'd1;
    send(b, 0);
    lit_q.push_back(mk(0, 0, 0, 1, 0));
    lit_q.push_back(mk(15, 0, 0, 0, 0));
    lit_q.push_back(mk(3, 1, 1, 0, 0));
    lit_q.push_back(mk(0, 0, 0, 0, 1));
    cmp_lits("zrl_run");
    b = '0; b[63] = 11'h400;
    send(b, 0);
    lit_q.push_back(mk(0, 0, 0, 1, 0));
    for (int i = 0; i < 3; i++) lit_q.push_back(mk(15, 0, 0, 0, 0));
    lit_q.push_back(mk(14, 11, 11'h3FF, 0, 1));
    cmp_lits("last63");
    b = '0; b[0] = 11'd100;
    send(b, 0);
    lit_q.push_back(mk(0, 7, 100, 1, 0));
    lit_q.push_back(mk(0, 0, 0, 0, 1));
    cmp_lits("dc100");
    b[0] = 11'd98;
    send(b, 0);
    lit_q.push_back(mk(0, 2, 1, 1, 0));
    lit_q.push_back(mk(0, 0, 0, 0, 1));
    cmp_lits("dc_pred");
    clear_dc();
    send(b, 0);
    lit_q.push_back(mk(0, 7, 98, 1, 0));
    lit_q.push_back(mk(0, 0, 0, 0, 1));
    cmp_lits("dc_cleared");
    b[0] = 11'd50;
    send(b, 1);
    send(b, 0);
    lit_q.push_back(mk(0, 0, 0, 1, 0));
    lit_q.push_back(mk(0, 0, 0, 0, 1));
    cmp_lits("clear_vs_hs");
    rand_en = 1;
    b = '0; b[0] = 11'h400; b[1] = 11'd1023; b[2] = -11'sd1; b[5] = 11'd7;
    b[17] = -11'sd512; b[40] = 11'd2; b[62] = -11'sd5;
    send(b, 0);
    for (int k = 0; k < 3; k++) begin
      b = '0;
      for (int i = 0; i < 64; i++) if ($urandom_range(0, 5) == 0) b[i] = W'($urandom);
      send(b, 0);
    end
    b = '0; b[0] = 11'd3; b[30] = 11'd4; b[60] = 11'd1;
    cap_q.delete();
    model(b, m_prev);
    in_block = b;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (6) @(posedge clk);
    #3;
    rst = 1;
    exp_q.delete();
    #1;
    chk("rst_async_valid", int'(out_valid), 0);
    chk("rst_async_out", int'(got), 0);
    @(posedge clk); #1;
    rst = 0;
    m_prev = 0;
    rand_en = 0;
    #1;
    chk("rst_mid_ready", int'(in_ready), 1);
    repeat (5) @(posedge clk);
    #1;
    chk("no_partial", int'(out_valid), 0);
    b = '0; b[0] = 11'd7;
    send(b, 0);
    lit_q.push_back(mk(0, 3, 7, 1, 0));
    lit_q.push_back(mk(0, 0, 0, 0, 1));
    cmp_lits("post_rst");
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end
endmodule
